// File: rtl/gic_pkg.sv
// rtl/gic_pkg.sv - nibble codes, FSM states and frame lengths for the GIC nibble link
package gic_pkg;

  localparam logic [3:0] GIC_WR   = 4'hA;
  localparam logic [3:0] GIC_RD   = 4'h5;
  localparam logic [3:0] GIC_ACK  = 4'h3;
  localparam logic [3:0] GIC_ERR  = 4'h9;
  localparam logic [3:0] GIC_IDLE = 4'h0;

  localparam int GIC_WORD_NIBS = 8;
  localparam int GIC_WR_FRAME  = 18;
  localparam int GIC_RD_FRAME  = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_HDR,
    S_TX_ADR,
    S_TX_SEL,
    S_TX_DAT,
    S_WAIT_RSP,
    S_RX_DAT,
    S_DONE
  } gic_state_t;

endpackage

// File: rtl/gic_nib_shift.sv
// rtl/gic_nib_shift.sv - 32-bit nibble shift register: parallel load, shift out MSB nibble, shift in at LSB
module gic_nib_shift
  import gic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        shift,
  input  logic [3:0]  shift_nib,
  output logic [31:0] word,
  output logic [3:0]  top_nib,
  output logic        last,
  output logic        done
);

  logic [2:0] cnt;

  // done goes high once a full word has been shifted since the last load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= 32'h0;
      cnt  <= 3'd0;
      done <= 1'b0;
    end else if (load) begin
      word <= load_word;
      cnt  <= 3'd0;
      done <= 1'b0;
    end else if (shift) begin
      word <= {word[27:0], shift_nib};
      cnt  <= cnt + 3'd1;
      done <= last;
    end
  end

  assign top_nib = word[31:28];
  assign last    = (cnt == 3'(GIC_WORD_NIBS - 1));

endmodule

// File: rtl/gic_master.sv
// rtl/gic_master.sv - Wishbone classic slave tunnelling each bus cycle over the 4-bit GIC link
module gic_master
  import gic_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [3:0]  IDLE_NIB = GIC_IDLE
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  input  logic [3:0]  gic_dat_i,
  output logic [3:0]  gic_dat_o
);

  gic_state_t  state;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic [3:0]  rsp_q;
  logic [31:0] timer;
  logic        req;
  logic        timed_out;
  logic        tx_load, tx_shift, tx_last, tx_done;
  logic [31:0] tx_load_word, tx_word;
  logic [3:0]  tx_nib;
  logic        rx_load, rx_shift, rx_last, rx_done;
  logic [3:0]  rx_nib;
  logic        unused;

  assign req       = wb_cyc_i & wb_stb_i;
  assign wb_rty_o  = 1'b0;
  assign timed_out = (TIMEOUT != 0) && (timer == TIMEOUT - 1);
  assign unused    = ^{wb_cti_i, wb_bte_i, tx_word, tx_last, rx_nib, rx_done};

  // TX holds the address first and is reloaded with write data as the last address nibble goes out
  always_comb begin
    tx_load      = 1'b0;
    tx_load_word = dat_q;
    tx_shift     = 1'b0;
    rx_load      = 1'b0;
    rx_shift     = 1'b0;
    case (state)
      S_IDLE: begin
        tx_load      = req;
        tx_load_word = wb_adr_i;
      end
      S_TX_HDR:   tx_shift = 1'b1;
      S_TX_ADR: begin
        tx_load  = tx_done;
        tx_shift = !tx_done;
      end
      S_TX_SEL:   tx_shift = we_q;
      S_TX_DAT:   tx_shift = !tx_done;
      S_WAIT_RSP: rx_load  = (rsp_q == GIC_ACK) && !we_q;
      S_RX_DAT:   rx_shift = 1'b1;
      default: ;
    endcase
  end

  gic_nib_shift u_tx (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .load      (tx_load),
    .load_word (tx_load_word),
    .shift     (tx_shift),
    .shift_nib (4'h0),
    .word      (tx_word),
    .top_nib   (tx_nib),
    .last      (tx_last),
    .done      (tx_done)
  );

  // RX reloads its own contents so only the nibble counter restarts; read data survives writes and errors
  gic_nib_shift u_rx (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .load      (rx_load),
    .load_word (wb_dat_o),
    .shift     (rx_shift),
    .shift_nib (rsp_q),
    .word      (wb_dat_o),
    .top_nib   (rx_nib),
    .last      (rx_last),
    .done      (rx_done)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      dat_q     <= 32'h0;
      rsp_q     <= IDLE_NIB;
      timer     <= 32'h0;
      gic_dat_o <= IDLE_NIB;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
    end else begin
      rsp_q <= gic_dat_i;
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q      <= wb_we_i;
            sel_q     <= wb_sel_i;
            dat_q     <= wb_dat_i;
            gic_dat_o <= wb_we_i ? GIC_WR : GIC_RD;
            state     <= S_TX_HDR;
          end
        end
        S_TX_HDR: begin
          gic_dat_o <= tx_nib;
          state     <= S_TX_ADR;
        end
        S_TX_ADR: begin
          if (tx_done) begin
            gic_dat_o <= sel_q;
            state     <= S_TX_SEL;
          end else begin
            gic_dat_o <= tx_nib;
          end
        end
        S_TX_SEL: begin
          if (we_q) begin
            gic_dat_o <= tx_nib;
            state     <= S_TX_DAT;
          end else begin
            gic_dat_o <= IDLE_NIB;
            timer     <= 32'h0;
            state     <= S_WAIT_RSP;
          end
        end
        S_TX_DAT: begin
          if (tx_done) begin
            gic_dat_o <= IDLE_NIB;
            timer     <= 32'h0;
            state     <= S_WAIT_RSP;
          end else begin
            gic_dat_o <= tx_nib;
          end
        end
        // a response always wins over a timeout expiring in the same cycle
        S_WAIT_RSP: begin
          timer <= timer + 32'd1;
          if (rsp_q == IDLE_NIB) begin
            if (timed_out) begin
              wb_err_o <= wb_cyc_i;
              state    <= S_DONE;
            end
          end else if (rsp_q == GIC_ACK && !we_q) begin
            state <= S_RX_DAT;
          end else begin
            wb_ack_o <= wb_cyc_i && (rsp_q == GIC_ACK);
            wb_err_o <= wb_cyc_i && (rsp_q != GIC_ACK);
            state    <= S_DONE;
          end
        end
        S_RX_DAT: begin
          if (rx_last) begin
            wb_ack_o <= wb_cyc_i;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gic_master.sv
// tb/tb_gic_master.sv - scoreboard bench for gic_master against a behavioural remote link end
module tb_gic_master;
  import gic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [3:0]  gic_dat_i = 4'h0, gic_dat_o;

  always #5 clk = ~clk;

  gic_master #(.TIMEOUT(16), .IDLE_NIB(GIC_IDLE)) dut (
    .wb_clk_i (clk),      .wb_rst_n_i (rst_n),
    .wb_adr_i (wb_adr_i), .wb_dat_i (wb_dat_i), .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),  .wb_cyc_i (wb_cyc_i), .wb_stb_i (wb_stb_i),
    .wb_cti_i (wb_cti_i), .wb_bte_i (wb_bte_i), .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o), .wb_err_o (wb_err_o), .wb_rty_o (wb_rty_o),
    .gic_dat_i(gic_dat_i), .gic_dat_o(gic_dat_o)
  );

  typedef struct {
    logic [1:0]  kind;   // {ack, err}
    logic [31:0] data;
    int          lat;    // cycles from header seen on the link to the pulse
  } rsp_t;

  localparam logic [1:0] K_ACK = 2'b10;
  localparam logic [1:0] K_ERR = 2'b01;

  int         checks = 0, errors = 0;
  int         cyc_cnt = 0, hdr_cnt = 0;
  int         cfg_delay = 1, drv_delay = 0, frame_left = 0;
  rsp_t       exp_rsp[$];
  rsp_t       mon_e;
  logic [3:0] exp_nib[$];
  logic [3:0] cfg_nibs[$];
  logic [3:0] drv_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // remote end: checks request nibbles, then plays the configured response after the frame
  always @(negedge clk) begin
    if (!rst_n) begin
      frame_left = 0;
      drv_delay  = 0;
      drv_q.delete();
      exp_nib.delete();
      gic_dat_i  = GIC_IDLE;
    end else begin
      if (drv_delay > 0) drv_delay--;
      if (drv_delay == 0 && drv_q.size() > 0) gic_dat_i = drv_q.pop_front();
      else gic_dat_i = GIC_IDLE;
      if (frame_left == 0 && gic_dat_o != GIC_IDLE) begin
        hdr_cnt    = cyc_cnt;
        frame_left = (gic_dat_o == GIC_WR) ? GIC_WR_FRAME : (gic_dat_o == GIC_RD) ? GIC_RD_FRAME : 1;
      end
      if (frame_left > 0) begin
        if (exp_nib.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_nib: got %h with no nibble expected", gic_dat_o);
        end else begin
          check("frame_nib", 32'(gic_dat_o), 32'(exp_nib.pop_front()));
        end
        frame_left--;
        if (frame_left == 0) begin
          drv_q     = cfg_nibs;
          drv_delay = cfg_delay;
        end
      end
    end
  end

  // bus monitor: every ack/err pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && (wb_ack_o || wb_err_o)) begin
      if (exp_rsp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: ack=%0b err=%0b, none expected", wb_ack_o, wb_err_o);
      end else begin
        mon_e = exp_rsp.pop_front();
        check("rsp_kind", 32'({wb_ack_o, wb_err_o}), 32'(mon_e.kind));
        check("rsp_data", wb_dat_o, mon_e.data);
        check("rsp_latency", 32'(cyc_cnt - hdr_cnt), 32'(mon_e.lat));
      end
    end
  end

  task automatic setup(input logic [71:0] frame, input int flen, input int delay,
                       input logic [35:0] rsp, input int rlen);
    cfg_delay = delay;
    cfg_nibs.delete();
    for (int i = rlen - 1; i >= 0; i--) cfg_nibs.push_back(rsp[4*i +: 4]);
    for (int i = flen - 1; i >= 0; i--) exp_nib.push_back(frame[4*i +: 4]);
  endtask

  task automatic start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    @(posedge clk);
    #1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
  endtask

  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [71:0] frame, input int delay,
                     input logic [35:0] rsp, input int rlen, input logic [1:0] kind,
                     input logic [31:0] edata, input int lat);
    int n;
    setup(frame, we ? GIC_WR_FRAME : GIC_RD_FRAME, delay, rsp, rlen);
    exp_rsp.push_back('{kind, edata, lat});
    start(we, adr, dat, sel);
    n = 0;
    while (!(wb_ack_o || wb_err_o) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) begin
      checks++;
      errors++;
      $display("FAIL wait_pulse: no ack/err within %0d cycles, adr %h", n, adr);
    end
    @(posedge clk);
    #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_gic_dat_o", 32'(gic_dat_o), 32'h0);
    check("reset_ack", 32'(wb_ack_o), 32'h0);
    check("reset_err", 32'(wb_err_o), 32'h0);
    check("reset_dat_o", wb_dat_o, 32'h0);
    check("reset_rty", 32'(wb_rty_o), 32'h0);
    rst_n = 1'b1;

    // write, response two cycles after the frame
    txn(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF, 72'hA_0000_1234_F_DEAD_BEEF, 2,
        36'h3, 1, K_ACK, 32'h0, 21);
    // read at minimum latency
    txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, 72'h5_8000_0010_F, 1,
        36'h3_1234_5678, 9, K_ACK, 32'h1234_5678, 20);
    // read answered with err: data holds
    txn(1'b0, 32'h0000_0100, 32'h0, 4'h3, 72'h5_0000_0100_3, 1,
        36'h9, 1, K_ERR, 32'h1234_5678, 12);
    // silent remote: timeout err, late ack while idle is ignored
    txn(1'b0, 32'h0000_0004, 32'h0, 4'hF, 72'h5_0000_0004_F, 25,
        36'h3, 1, K_ERR, 32'h1234_5678, 26);
    repeat (20) @(posedge clk);
    // sel=0 write still sends the full frame
    txn(1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'h0, 72'hA_FFFF_FFFC_0_0000_0001, 1,
        36'h3, 1, K_ACK, 32'h1234_5678, 20);
    // protocol error nibble
    txn(1'b1, 32'h0000_0020, 32'h5555_AAAA, 4'hC, 72'hA_0000_0020_C_5555_AAAA, 1,
        36'h7, 1, K_ERR, 32'h1234_5678, 20);
    txn(1'b0, 32'h0000_0ABC, 32'h0, 4'h1, 72'h5_0000_0ABC_1, 3,
        36'h3_ABCD_0123, 9, K_ACK, 32'hABCD_0123, 22);

    // cyc dropped mid-frame: frame completes, no pulse
    setup(72'hA_0000_0040_F_0000_00FF, GIC_WR_FRAME, 1, 36'h3, 1);
    start(1'b1, 32'h0000_0040, 32'h0000_00FF, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (40) @(posedge clk);
    check("drop_frame_done", 32'(exp_nib.size()), 32'h0);

    // reset while address nibbles are on the link
    setup(72'hA_9876_5432_F_2222_3333, GIC_WR_FRAME, 1, 36'h3, 1);
    start(1'b1, 32'h9876_5432, 32'h2222_3333, 4'hF);
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_link", 32'(gic_dat_o), 32'h7);
    rst_n = 1'b0;
    #1;
    check("async_rst_gic_dat_o", 32'(gic_dat_o), 32'h0);
    check("async_rst_ack", 32'(wb_ack_o), 32'h0);
    check("async_rst_err", 32'(wb_err_o), 32'h0);
    check("async_rst_dat_o", wb_dat_o, 32'h0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    txn(1'b1, 32'h0000_1111, 32'h2222_3333, 4'hF, 72'hA_0000_1111_F_2222_3333, 1,
        36'h3, 1, K_ACK, 32'h0, 20);

    repeat (10) @(posedge clk);
    check("rsp_queue_empty", 32'(exp_rsp.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
